// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared constants, fetch FSM states and byte-order helper for the fetch/align unit
package cpu_fetch_pkg;
  localparam int MAX_OPE_LEN = 5;
  localparam logic [7:0] OP_PUSH_EBP = 8'h55;
  localparam logic [7:0] OP_MOV = 8'h89;
  localparam logic [7:0] OP_MOV_EAX = 8'hb8;
  localparam logic [7:0] OP_POP_EBP = 8'h5d;
  localparam logic [7:0] OP_RET = 8'hc3;
  localparam logic [7:0] OP_LOOP = 8'he2;
  localparam logic [7:0] OP_PUSH_IMM = 8'h6a;
  typedef enum logic {FS_IDLE, FS_WAIT} fetch_state_t;
  function automatic logic [31:0] msb_first(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/fetch_byte_buf.sv
// fetch_byte_buf: byte shift buffer (byte 0 = byte at eip) with count, shift-by-n and append-with-skip
module fetch_byte_buf
  import cpu_fetch_pkg::*;
#(
  parameter int BUF_BYTES = 8,
  localparam int CW = $clog2(BUF_BYTES + 1)
) (
  input  logic          clk2,
  input  logic          reset_n,
  input  logic          clr,
  input  logic [3:0]    shift_n,
  input  logic          app,
  input  logic [31:0]   app_data,
  input  logic [1:0]    app_skip,
  output logic [CW-1:0] count,
  output logic [31:0]   ope,
  output logic [7:0]    ope_ext
);
  localparam int BW = 8 * BUF_BYTES;
  logic [BW-1:0] q, q_nxt;
  logic [CW-1:0] rem, cnt_nxt;
  // bytes past count are kept zero, so a plain shift-and-or does both the consume and the append
  always_comb begin
    rem = count - CW'(shift_n);
    q_nxt = clr ? '0 : (q >> {shift_n, 3'b000}) | (app ? (BW'(app_data >> {app_skip, 3'b000}) << {rem, 3'b000}) : '0);
    cnt_nxt = clr ? '0 : rem + (app ? CW'(3'd4 - 3'(app_skip)) : '0);
  end
  always_ff @(posedge clk2 or negedge reset_n)
    if (!reset_n) begin
      q <= '0;
      count <= '0;
    end else begin
      q <= q_nxt;
      count <= cnt_nxt;
    end
  assign ope = msb_first(q[31:0]);
  assign ope_ext = q[39:32];
endmodule

// File: rtl/fetch_align.sv
// fetch_align: instruction fetch/align unit feeding the decoder's 32-bit ope window
// FETCH_ERR_EN adds a sticky adv_err output flagging illegal advance requests.
module fetch_align
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BUF_BYTES = 8,
  parameter logic [ADDR_W-1:0] RESET_EIP = '0
) (
  input  logic              clk2,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ope,
  output logic [7:0]        ope_ext,
  output logic              ope_valid,
  input  logic              advance,
  input  logic [3:0]        num_of_ope,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_eip,
`ifdef FETCH_ERR_EN
  output logic              adv_err,
`endif
  output logic [ADDR_W-1:0] eip
);
  localparam int CW = $clog2(BUF_BYTES + 1);
  fetch_state_t state, state_nxt;
  logic [ADDR_W-1:0] fptr;
  logic [1:0] skip;
  logic drop, adv_ok, take;
  logic [CW-1:0] count;
  assign ope_valid = count >= CW'(MAX_OPE_LEN);
  assign adv_ok = advance && ope_valid && num_of_ope <= 4'(MAX_OPE_LEN) && !redirect;
  assign take = state == FS_WAIT && mem_ack && !drop && !redirect;
  assign mem_req = state == FS_WAIT;
  always_comb begin
    state_nxt = state;
    state_nxt = state == FS_IDLE ? ((count <= CW'(BUF_BYTES - 4) && !redirect) ? FS_WAIT : FS_IDLE)
                                 : (mem_ack ? FS_IDLE : FS_WAIT);
  end
  // a redirect while a read is in flight leaves the bus alone and just discards the answer
  always_ff @(posedge clk2 or negedge reset_n)
    if (!reset_n) begin
      state <= FS_IDLE;
      eip <= RESET_EIP;
      fptr <= {RESET_EIP[ADDR_W-1:2], 2'b00};
      mem_addr <= {RESET_EIP[ADDR_W-1:2], 2'b00};
      skip <= RESET_EIP[1:0];
      drop <= 1'b0;
    end else begin
      state <= state_nxt;
      eip <= redirect ? redirect_eip : adv_ok ? eip + ADDR_W'(num_of_ope) : eip;
      fptr <= redirect ? {redirect_eip[ADDR_W-1:2], 2'b00} : take ? fptr + ADDR_W'(4) : fptr;
      skip <= redirect ? redirect_eip[1:0] : take ? 2'b00 : skip;
      drop <= (mem_req && mem_ack) ? 1'b0 : (mem_req && redirect) ? 1'b1 : drop;
      mem_addr <= (state == FS_IDLE && state_nxt == FS_WAIT) ? fptr : mem_addr;
    end
`ifdef FETCH_ERR_EN
  always_ff @(posedge clk2 or negedge reset_n)
    if (!reset_n) adv_err <= 1'b0;
    else if (advance && (num_of_ope > 4'(MAX_OPE_LEN) || !ope_valid)) adv_err <= 1'b1;
`endif
  fetch_byte_buf #(.BUF_BYTES(BUF_BYTES)) u_buf (
    .clk2(clk2),
    .reset_n(reset_n),
    .clr(redirect),
    .shift_n(adv_ok ? num_of_ope : 4'd0),
    .app(take),
    .app_data(mem_rdata),
    .app_skip(skip),
    .count(count),
    .ope(ope),
    .ope_ext(ope_ext)
  );
endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: directed bench for fetch_align with a latency-configurable memory responder
module tb_fetch_align;
  logic clk2 = 1'b0, reset_n;
  logic mem_req, mem_ack, ope_valid, advance, redirect;
  logic [31:0] mem_addr, mem_rdata, ope, eip, redirect_eip;
  logic [7:0] ope_ext;
  logic [3:0] num_of_ope;
`ifdef FETCH_ERR_EN
  logic adv_err;
`endif
  int vectors = 0, miscompares = 0, lat = 1, wcnt;
  always #5 clk2 = ~clk2;
  fetch_align #(.ADDR_W(32), .BUF_BYTES(12), .RESET_EIP(32'h0)) dut (
    .clk2(clk2), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ope(ope), .ope_ext(ope_ext),
    .ope_valid(ope_valid), .advance(advance), .num_of_ope(num_of_ope),
    .redirect(redirect), .redirect_eip(redirect_eip),
`ifdef FETCH_ERR_EN
    .adv_err(adv_err),
`endif
    .eip(eip)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    case (a)
      32'h000: return 32'h0000e589;
      32'h004: return 32'h00000055;
      32'h008: return 32'h0000c35d;
      32'h104: return 32'h0000b855;
      32'h108: return 32'h44332211;
      32'h200: return 32'h77665544;
      default: return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endcase
  endfunction
  // responder acts 2 time units after the rising edge, acking after lat cycles of mem_req
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    wcnt = 0;
    forever begin
      @(posedge clk2);
      #2;
      if (!reset_n || mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req) begin
        wcnt++;
        if (wcnt >= lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wcnt = 0;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk2);
  endtask
  task automatic wait_valid(input string tag);
    int i;
    for (i = 0; i < 40 && !ope_valid; i++) tick();
    vectors++;
    if (!ope_valid) begin
      miscompares++;
      $display("FAIL %s_valid_timeout: ope_valid=%b required 1", tag, ope_valid);
    end
  endtask
  task automatic test_reset();
    int c;
    reset_n = 1'b0;
    advance = 1'b0;
    num_of_ope = '0;
    redirect = 1'b0;
    redirect_eip = '0;
    tick(3);
    vectors++;
    if ({eip, ope, ope_ext, ope_valid, mem_req} !== {32'h0, 32'h0, 8'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: eip=%h ope=%h ext=%h valid=%b req=%b required all 0", eip, ope, ope_ext, ope_valid, mem_req);
    end
`ifdef FETCH_ERR_EN
    vectors++;
    if (adv_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_adv_err: got %b required 0", adv_err);
    end
`endif
    reset_n = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL first_req: req=%b addr=%h required 1/00000000", mem_req, mem_addr);
    end
    c = 1;
    while (!ope_valid && c < 20) begin
      tick();
      c++;
    end
    vectors++;
    if (c !== 4) begin
      miscompares++;
      $display("FAIL valid_latency: %0d cycles required 4", c);
    end
    vectors++;
    if (ope !== 32'h89e50000 || ope_ext !== 8'h55 || eip !== 32'h0) begin
      miscompares++;
      $display("FAIL first_ope: ope=%h ext=%h eip=%h required 89e50000/55/00000000", ope, ope_ext, eip);
    end
  endtask
  task automatic test_advance();
    advance = 1'b1;
    num_of_ope = 4'd2;
    tick();
    advance = 1'b0;
    vectors++;
    if (eip !== 32'h2 || ope !== 32'h00005500 || ope_ext !== 8'h00) begin
      miscompares++;
      $display("FAIL advance2: eip=%h ope=%h ext=%h required 00000002/00005500/00", eip, ope, ope_ext);
    end
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL next_fetch: req=%b addr=%h required 1/00000008", mem_req, mem_addr);
    end
  endtask
  task automatic test_redirect();
    tick();
    redirect = 1'b1;
    redirect_eip = 32'h105;
    tick();
    redirect = 1'b0;
    vectors++;
    if (eip !== 32'h105 || ope !== 32'h0 || ope_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_clear: eip=%h ope=%h valid=%b required 00000105/00000000/0", eip, ope, ope_valid);
    end
    wait_valid("redirect");
    vectors++;
    if (ope !== 32'hb8000011 || ope_ext !== 8'h22 || eip !== 32'h105) begin
      miscompares++;
      $display("FAIL redirect_skip: ope=%h ext=%h eip=%h required b8000011/22/00000105", ope, ope_ext, eip);
    end
  endtask
  task automatic test_redirect_wait();
    int i;
    logic held_ok;
    tick(6);
    lat = 3;
    advance = 1'b1;
    num_of_ope = 4'd5;
    tick();
    advance = 1'b0;
    vectors++;
    if (eip !== 32'h10a || ope !== 32'h33440c0d || ope_ext !== 8'h0e) begin
      miscompares++;
      $display("FAIL advance5: eip=%h ope=%h ext=%h required 0000010a/33440c0d/0e", eip, ope, ope_ext);
    end
    for (i = 0; i < 10 && !mem_req; i++) tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h110) begin
      miscompares++;
      $display("FAIL wait_req: req=%b addr=%h required 1/00000110", mem_req, mem_addr);
    end
    redirect = 1'b1;
    redirect_eip = 32'h202;
    tick();
    redirect = 1'b0;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h110 || eip !== 32'h202) begin
      miscompares++;
      $display("FAIL redirect_in_wait: req=%b addr=%h eip=%h required 1/00000110/00000202", mem_req, mem_addr, eip);
    end
    held_ok = 1'b1;
    for (i = 0; i < 10 && mem_req; i++) begin
      if (mem_addr !== 32'h110) held_ok = 1'b0;
      tick();
    end
    vectors++;
    if (!held_ok || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL addr_held: held=%b req=%b required 1/0", held_ok, mem_req);
    end
    for (i = 0; i < 10 && !mem_req; i++) tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL new_req: req=%b addr=%h required 1/00000200", mem_req, mem_addr);
    end
    wait_valid("drop");
    vectors++;
    if (ope !== 32'h66770405 || ope_ext !== 8'h06 || eip !== 32'h202) begin
      miscompares++;
      $display("FAIL drop_data: ope=%h ext=%h eip=%h required 66770405/06/00000202", ope, ope_ext, eip);
    end
  endtask
  task automatic test_adv_ack();
    int i;
    redirect = 1'b1;
    redirect_eip = 32'h300;
    tick();
    redirect = 1'b0;
    for (i = 0; i < 80 && !(mem_req && mem_addr == 32'h308); i++) tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h308 || ope !== 32'h00010203 || ope_ext !== 8'h04) begin
      miscompares++;
      $display("FAIL fill8: req=%b addr=%h ope=%h ext=%h required 1/00000308/00010203/04", mem_req, mem_addr, ope, ope_ext);
    end
    advance = 1'b1;
    num_of_ope = 4'd3;
    tick();
    advance = 1'b0;
    vectors++;
    if (eip !== 32'h303 || ope !== 32'h03040506 || ope_ext !== 8'h07 || ope_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL count5: eip=%h ope=%h ext=%h valid=%b required 00000303/03040506/07/1", eip, ope, ope_ext, ope_valid);
    end
    for (i = 0; i < 6 && !mem_ack; i++) tick();
    vectors++;
    if (mem_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_timeout: mem_ack=%b required 1", mem_ack);
    end
    advance = 1'b1;
    num_of_ope = 4'd5;
    tick();
    advance = 1'b0;
    vectors++;
    if (eip !== 32'h308 || ope !== 32'h08090a0b || ope_ext !== 8'h00 || ope_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL adv_with_ack: eip=%h ope=%h ext=%h valid=%b required 00000308/08090a0b/00/0", eip, ope, ope_ext, ope_valid);
    end
    wait_valid("refill");
    vectors++;
    if (ope !== 32'h08090a0b || ope_ext !== 8'h0c || eip !== 32'h308) begin
      miscompares++;
      $display("FAIL refill8: ope=%h ext=%h eip=%h required 08090a0b/0c/00000308", ope, ope_ext, eip);
    end
  endtask
  task automatic test_illegal();
    advance = 1'b1;
    num_of_ope = 4'd7;
    tick();
    advance = 1'b0;
    vectors++;
    if (eip !== 32'h308 || ope !== 32'h08090a0b) begin
      miscompares++;
      $display("FAIL num7_ignored: eip=%h ope=%h required 00000308/08090a0b", eip, ope);
    end
`ifdef FETCH_ERR_EN
    vectors++;
    if (adv_err !== 1'b1) begin
      miscompares++;
      $display("FAIL adv_err_set: got %b required 1", adv_err);
    end
`endif
    redirect = 1'b1;
    redirect_eip = 32'h400;
    tick();
    redirect = 1'b0;
    advance = 1'b1;
    num_of_ope = 4'd1;
    tick();
    advance = 1'b0;
    vectors++;
    if (eip !== 32'h400) begin
      miscompares++;
      $display("FAIL invalid_adv_ignored: eip=%h required 00000400", eip);
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if (eip !== 32'h0 || mem_req !== 1'b0 || ope_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rereset: eip=%h req=%b valid=%b required 00000000/0/0", eip, mem_req, ope_valid);
    end
`ifdef FETCH_ERR_EN
    vectors++;
    if (adv_err !== 1'b0) begin
      miscompares++;
      $display("FAIL adv_err_clear: got %b required 0", adv_err);
    end
`endif
    reset_n = 1'b1;
    tick(2);
  endtask
  initial begin
    test_reset();
    test_advance();
    test_redirect();
    test_redirect_wait();
    test_adv_ack();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
